// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// State encodings are fixed 3-bit values so they stay readable in waveforms.
package fetch_sequencer_pkg;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

   typedef enum logic [2:0] {
      FSEQ_IDLE  = 3'd0,
      FSEQ_REQ   = 3'd1,
      FSEQ_WAIT  = 3'd2,
      FSEQ_HOLD  = 3'd3,
      FSEQ_FAULT = 3'd4
   } fseq_state_e;

   function automatic logic is_word_aligned(input logic [1:0] addr_lsbs);
      return addr_lsbs == 2'b00;
   endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Program counter owner: issues one handshaked instruction fetch at a time,
// presents the returned word until it retires, then picks the next PC.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   input  logic            stall,
   input  logic            take_branch,
   input  logic [XLEN-1:0] branch_target,
   output logic            instr_valid,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] instr_pc,
   output logic [XLEN-1:0] instret,
   output logic            misalign_err
);

   fseq_state_e     state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_plus4;
   logic            target_ok;

   // pc is only updated on retire, so it doubles as the stable request address.
   assign imem_addr = pc;
   assign pc_plus4  = pc + XLEN'(4);
   assign target_ok = is_word_aligned(branch_target[1:0]);

   // NOTE: every register here uses <= so all updates within a cycle see the
   // pre-edge values of pc/state, regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= FSEQ_IDLE;
         pc           <= RESET_VECTOR;
         imem_req     <= 1'b0;
         instr_valid  <= 1'b0;
         instr        <= INSTR_NOP;
         instr_pc     <= '0;
         instret      <= '0;
         misalign_err <= 1'b0;
      end else begin
         case (state)
            FSEQ_IDLE: begin
               state    <= FSEQ_REQ;
               imem_req <= 1'b1;
            end

            FSEQ_REQ: begin
               if (imem_gnt) begin
                  state    <= FSEQ_WAIT;
                  imem_req <= 1'b0;
               end
            end

            FSEQ_WAIT: begin
               if (imem_rvalid) begin
                  state       <= FSEQ_HOLD;
                  instr       <= imem_rdata;
                  instr_pc    <= pc;
                  instr_valid <= 1'b1;
               end
            end

            FSEQ_HOLD: begin
               if (!stall) begin
                  instr_valid <= 1'b0;
                  if (take_branch && !target_ok) begin
                     // Faulting instruction is dropped, not retired.
                     state        <= FSEQ_FAULT;
                     misalign_err <= 1'b1;
                  end else begin
                     state    <= FSEQ_REQ;
                     imem_req <= 1'b1;
                     instret  <= instret + XLEN'(1);
                     pc       <= take_branch ? branch_target : pc_plus4;
                  end
               end
            end

            FSEQ_FAULT: begin
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
            end

            default: begin
               state       <= FSEQ_IDLE;
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed table, randomized
// transactions against a transaction-level PC/instret model, reset corners.
module tb_fetch_sequencer;
   import fetch_sequencer_pkg::*;

   localparam logic [31:0] RV_B = 32'hFFFF_FFFC;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_gnt, imem_rvalid, stall, take_branch;
   logic [31:0] imem_rdata, branch_target;

   logic        imem_req, instr_valid, misalign_err;
   logic [31:0] imem_addr, instr, instr_pc, instret;
   logic        b_imem_req, b_instr_valid, b_misalign_err;
   logic [31:0] b_imem_addr, b_instr, b_instr_pc, b_instret;

   fetch_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .stall(stall), .take_branch(take_branch), .branch_target(branch_target),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .instret(instret), .misalign_err(misalign_err)
   );

   // Same stimulus, reset vector at the top of the address space.
   fetch_sequencer #(.XLEN(32), .RESET_VECTOR(RV_B)) dut_b (
      .clk(clk), .rst(rst),
      .imem_req(b_imem_req), .imem_addr(b_imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .stall(stall), .take_branch(take_branch), .branch_target(branch_target),
      .instr_valid(b_instr_valid), .instr(b_instr), .instr_pc(b_instr_pc),
      .instret(b_instret), .misalign_err(b_misalign_err)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_pc, exp_pc_b, exp_instret;

   typedef struct {
      int          gd;
      int          rd;
      int          sc;
      logic        tk;
      logic [31:0] tgt;
      logic [31:0] next_pc;
      logic [31:0] instret;
   } vec_t;

   vec_t tab[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_reset_outputs(input string tag, input logic [31:0] rv_a, input logic [31:0] rv_b);
      check({tag, "_req"},    {31'd0, imem_req},     32'd0);
      check({tag, "_valid"},  {31'd0, instr_valid},  32'd0);
      check({tag, "_instr"},  instr,                 INSTR_NOP);
      check({tag, "_ipc"},    instr_pc,              32'd0);
      check({tag, "_instret"}, instret,              32'd0);
      check({tag, "_err"},    {31'd0, misalign_err}, 32'd0);
      check({tag, "_addr"},   imem_addr,             rv_a);
      check({tag, "_addr_b"}, b_imem_addr,           rv_b);
   endtask

   task automatic model_reset();
      exp_pc      = 32'h0;
      exp_pc_b    = RV_B;
      exp_instret = 32'h0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      stall = 1'b1; take_branch = 1'b0; branch_target = 32'h0;
      repeat (2) @(negedge clk);
      check_reset_outputs("rst", 32'h0, RV_B);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      check("idle_to_req", {31'd0, imem_req}, 32'd1);
   endtask

   // One full fetch transaction; updates the model on retire.
   task automatic fetch_one(input int gd, input int rd, input int sc, input logic tk,
                            input logic [31:0] tgt, output bit faulted);
      logic [31:0] data;
      int          n;
      bit          fault_exp;
      data = $urandom;
      n = 0;
      while (!imem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("req_seen", {31'd0, imem_req}, 32'd1);
      check("req_addr", imem_addr, exp_pc);
      check("req_addr_b", b_imem_addr, exp_pc_b);
      for (int i = 0; i < gd; i++) begin
         imem_gnt = 1'b0;
         imem_rvalid = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("req_hold", {31'd0, imem_req}, 32'd1);
         check("addr_hold", imem_addr, exp_pc);
      end
      imem_gnt = 1'b1;
      imem_rvalid = 1'($urandom_range(0, 1));
      @(negedge clk);
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      check("wait_req", {31'd0, imem_req}, 32'd0);
      check("wait_valid", {31'd0, instr_valid}, 32'd0);
      for (int i = 0; i < rd; i++) begin
         imem_gnt = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("wait_req_hold", {31'd0, imem_req}, 32'd0);
         check("wait_valid_hold", {31'd0, instr_valid}, 32'd0);
      end
      imem_gnt = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata = data;
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata = $urandom;
      check("hold_valid", {31'd0, instr_valid}, 32'd1);
      check("hold_instr", instr, data);
      check("hold_ipc", instr_pc, exp_pc);
      check("hold_ipc_b", b_instr_pc, exp_pc_b);
      for (int i = 0; i < sc; i++) begin
         stall = 1'b1;
         take_branch = 1'($urandom_range(0, 1));
         branch_target = $urandom;
         imem_gnt = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("stall_valid", {31'd0, instr_valid}, 32'd1);
         check("stall_instr", instr, data);
         check("stall_ipc", instr_pc, exp_pc);
         check("stall_instret", instret, exp_instret);
         check("stall_req", {31'd0, imem_req}, 32'd0);
      end
      stall = 1'b0;
      take_branch = tk;
      branch_target = tgt;
      imem_gnt = 1'b0;
      @(negedge clk);
      stall = 1'b1;
      take_branch = 1'b0;
      fault_exp = tk && (tgt[1:0] != 2'b00);
      if (fault_exp) begin
         check("fault_err", {31'd0, misalign_err}, 32'd1);
         check("fault_valid", {31'd0, instr_valid}, 32'd0);
         check("fault_req", {31'd0, imem_req}, 32'd0);
         check("fault_instret", instret, exp_instret);
      end else begin
         exp_instret = exp_instret + 32'd1;
         exp_pc      = tk ? tgt : exp_pc + 32'd4;
         exp_pc_b    = tk ? tgt : exp_pc_b + 32'd4;
         check("retire_instret", instret, exp_instret);
         check("retire_valid", {31'd0, instr_valid}, 32'd0);
         check("retire_req", {31'd0, imem_req}, 32'd1);
         check("retire_addr", imem_addr, exp_pc);
         check("retire_err", {31'd0, misalign_err}, 32'd0);
      end
      faulted = fault_exp;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bit f;
      // gd, rd, sc, tk, tgt, next_pc, instret
      tab[0] = '{0, 0, 0, 1'b0, 32'h0,   32'h04,  32'd1};
      tab[1] = '{0, 0, 0, 1'b0, 32'h0,   32'h08,  32'd2};
      tab[2] = '{0, 0, 0, 1'b0, 32'h0,   32'h0C,  32'd3};
      tab[3] = '{0, 1, 0, 1'b0, 32'h0,   32'h10,  32'd4};
      tab[4] = '{4, 2, 0, 1'b0, 32'h0,   32'h14,  32'd5};
      tab[5] = '{0, 0, 5, 1'b0, 32'h0,   32'h18,  32'd6};
      tab[6] = '{1, 0, 1, 1'b0, 32'h0,   32'h1C,  32'd7};
      tab[7] = '{0, 3, 0, 1'b0, 32'h0,   32'h20,  32'd8};
      tab[8] = '{0, 0, 2, 1'b1, 32'h100, 32'h100, 32'd9};
      tab[9] = '{2, 1, 0, 1'b0, 32'h0,   32'h104, 32'd10};

      do_reset();
      for (int i = 0; i < 10; i++) begin
         fetch_one(tab[i].gd, tab[i].rd, tab[i].sc, tab[i].tk, tab[i].tgt, f);
         check("tab_next_addr", imem_addr, tab[i].next_pc);
         check("tab_instret", instret, tab[i].instret);
         if (i == 0) check("wrap_b_addr", b_imem_addr, 32'h0);
      end

      for (int i = 0; i < 40; i++) begin
         logic [31:0] t;
         t = $urandom & 32'hFFFF_FFFC;
         fetch_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), t, f);
      end
      fetch_one(0, 0, 0, 1'b1, 32'hFFFF_FFFC, f);
      fetch_one(0, 0, 0, 1'b0, 32'h0, f);
      check("pc_wrap", imem_addr, 32'h0);

      // Reset asserted mid-WAIT: outputs clear asynchronously.
      fetch_one(0, 0, 0, 1'b1, 32'h40, f);
      imem_gnt = 1'b1;
      @(negedge clk);
      imem_gnt = 1'b0;
      check("pre_rst_wait_req", {31'd0, imem_req}, 32'd0);
      #2 rst = 1'b1;
      #1 check_reset_outputs("async_rst", 32'h0, RV_B);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      check("restart_req", {31'd0, imem_req}, 32'd1);
      fetch_one(0, 1, 1, 1'b0, 32'h0, f);
      fetch_one(1, 0, 0, 1'b0, 32'h0, f);

      // Misaligned taken target: sticky fault until reset.
      fetch_one(0, 0, 2, 1'b1, 32'h102, f);
      check("fault_flag_b", {31'd0, b_misalign_err}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         imem_gnt = 1'($urandom_range(0, 1));
         imem_rvalid = 1'($urandom_range(0, 1));
         stall = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("fault_stay_req", {31'd0, imem_req}, 32'd0);
         check("fault_stay_err", {31'd0, misalign_err}, 32'd1);
         check("fault_stay_valid", {31'd0, instr_valid}, 32'd0);
         check("fault_stay_instret", instret, exp_instret);
      end
      do_reset();
      fetch_one(0, 0, 0, 1'b0, 32'h0, f);
      check("post_fault_addr", imem_addr, 32'h4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
